// File: rtl/instr_rom_pipe.sv
// Instruction fetch memory: block-RAM style synchronous read with a valid/ready
// handshake, explicit misaligned/out-of-range reporting and an optional output register.
module instr_rom_pipe #(
  parameter int          DEPTH_LOG2 = 8,
  parameter string       INIT_FILE  = "instr_rom.txt",
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
  parameter int          OUT_REG    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  misaligned;
  logic                  out_of_range;
  logic [DEPTH_LOG2-1:0] word_idx;

  logic        s1_valid;
  logic        s1_nop;
  logic        s1_adv;
  logic [31:0] ram_q;
  logic [31:0] s1_addr;
  logic [31:0] s1_instr;
  logic [1:0]  s1_err;

  assign misaligned   = |req_addr[1:0];
  assign out_of_range = |req_addr[31:DEPTH_LOG2+2];
  assign word_idx     = req_addr[DEPTH_LOG2+1:2];

  assign req_ready = rst_n && !flush && (!s1_valid || s1_adv);
  assign accept    = req_valid && req_ready;

  // Plain read register with no reset so it maps onto the RAM's own output latch.
  always_ff @(posedge clk) begin
    if (accept) ram_q <= mem[word_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_nop   <= 1'b1;
      s1_addr  <= 32'h0;
      s1_err   <= 2'b00;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (accept) begin
        s1_nop  <= misaligned || out_of_range;
        s1_addr <= req_addr;
        s1_err  <= {out_of_range, misaligned};
      end
    end
  end

  // Errored fetches (and the post-reset state) substitute the NOP after the RAM register.
  assign s1_instr = s1_nop ? NOP_WORD : ram_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic        s2_valid;
    logic [31:0] s2_instr;
    logic [31:0] s2_addr;
    logic [1:0]  s2_err;

    assign s1_adv = s1_valid && (!s2_valid || rsp_ready);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_instr <= NOP_WORD;
        s2_addr  <= 32'h0;
        s2_err   <= 2'b00;
      end else begin
        if (flush)          s2_valid <= 1'b0;
        else if (s1_adv)    s2_valid <= 1'b1;
        else if (rsp_ready) s2_valid <= 1'b0;
        if (s1_adv && !flush) begin
          s2_instr <= s1_instr;
          s2_addr  <= s1_addr;
          s2_err   <= s1_err;
        end
      end
    end

    assign rsp_valid = s2_valid;
    assign rsp_instr = s2_instr;
    assign rsp_addr  = s2_addr;
    assign rsp_err   = s2_err;
  end else begin : g_no_out_reg
    assign s1_adv    = s1_valid && rsp_ready;
    assign rsp_valid = s1_valid;
    assign rsp_instr = s1_instr;
    assign rsp_addr  = s1_addr;
    assign rsp_err   = s1_err;
  end

endmodule

// File: tb/tb_instr_rom_pipe.sv
// Directed bench for instr_rom_pipe: dut_a uses the output register, dut_b does not.
module tb_instr_rom_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        rsp_ready;
  logic [31:0] req_addr;

  logic        req_valid_a, req_ready_a, rsp_valid_a;
  logic [31:0] rsp_instr_a, rsp_addr_a;
  logic [1:0]  rsp_err_a;

  logic        req_valid_b, req_ready_b, rsp_valid_b;
  logic [31:0] rsp_instr_b, rsp_addr_b;
  logic [1:0]  rsp_err_b;

  int checks = 0;
  int errors = 0;
  int k;
  int n;

  logic [31:0] b_addr  [4] = '{32'h0000_03FC, 32'h0000_0402, 32'h0000_0400, 32'h0000_0006};
  logic [31:0] b_instr [4] = '{32'hA000_00FF, 32'h0, 32'h0, 32'h0};
  logic [1:0]  b_err   [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
  logic        bp_ready[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  instr_rom_pipe #(
    .DEPTH_LOG2(8), .INIT_FILE(""), .NOP_WORD(32'h0), .OUT_REG(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_a), .rsp_addr(rsp_addr_a), .rsp_err(rsp_err_a)
  );

  instr_rom_pipe #(
    .DEPTH_LOG2(8), .INIT_FILE(""), .NOP_WORD(32'h0), .OUT_REG(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_b), .rsp_addr(rsp_addr_b), .rsp_err(rsp_err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic va, input logic vb, input logic [31:0] addr,
                               input logic rr, input logic fl);
    req_valid_a = va;
    req_valid_b = vb;
    req_addr    = addr;
    rsp_ready   = rr;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dut_a.mem[i] = 32'hA000_0000 + i;
      dut_b.mem[i] = 32'hA000_0000 + i;
    end

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", {31'h0, rsp_valid_a}, 32'h0);
    checkOutput("rst_instr", rsp_instr_a, 32'h0);
    checkOutput("rst_addr", rsp_addr_a, 32'h0);
    checkOutput("rst_err", {30'h0, rsp_err_a}, 32'h0);
    checkOutput("rst_ready", {31'h0, req_ready_a}, 32'h0);
    checkOutput("rst_instr_b", rsp_instr_b, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready", {31'h0, req_ready_a}, 32'h1);

    // Streaming, latency 2: responses after the 2nd, 3rd and 4th edges.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(c < 3, 1'b0, c * 4, 1'b1, 1'b0);
      tick();
      if (c >= 1 && c <= 3) begin
        checkOutput("stream_valid", {31'h0, rsp_valid_a}, 32'h1);
        checkOutput("stream_instr", rsp_instr_a, 32'hA000_0000 + c - 1);
        checkOutput("stream_addr", rsp_addr_a, (c - 1) * 4);
        checkOutput("stream_err", {30'h0, rsp_err_a}, 32'h0);
      end else begin
        checkOutput("stream_idle", {31'h0, rsp_valid_a}, 32'h0);
      end
    end

    // Latency-1 instance: last word plus the three error cases.
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 1'b1, b_addr[j], 1'b1, 1'b0);
      tick();
      checkOutput("b_valid", {31'h0, rsp_valid_b}, 32'h1);
      checkOutput("b_instr", rsp_instr_b, b_instr[j]);
      checkOutput("b_addr", rsp_addr_b, b_addr[j]);
      checkOutput("b_err", {30'h0, rsp_err_b}, {30'h0, b_err[j]});
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("b_drain", {31'h0, rsp_valid_b}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();

    // Back-pressure: two accepts fill the pipe, then everything drains in order.
    k = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0, k * 4, 1'b0, 1'b0);
      #1;
      checkOutput("bp_ready", {31'h0, req_ready_a}, {31'h0, bp_ready[c]});
      if (bp_ready[c]) k++;
      tick();
      if (c >= 1) begin
        checkOutput("bp_hold_valid", {31'h0, rsp_valid_a}, 32'h1);
        checkOutput("bp_hold_instr", rsp_instr_a, 32'hA000_0000);
      end
    end
    n = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(k < 3, 1'b0, k * 4, 1'b1, 1'b0);
      #1;
      if (rsp_valid_a) begin
        if (n < 3) checkOutput("bp_order", rsp_instr_a, 32'hA000_0000 + n);
        else checkOutput("bp_extra", rsp_instr_a, 32'hFFFF_FFFF);
        n++;
      end
      if (req_valid_a && req_ready_a) k++;
      tick();
    end
    checkOutput("bp_count", n, 32'd3);

    // Flush with two fetches in flight.
    applyStimulus(1'b1, 1'b0, 32'h20, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h24, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h10, 1'b0, 1'b1);
    #1;
    checkOutput("flush_ready", {31'h0, req_ready_a}, 32'h0);
    checkOutput("flush_pre_valid", {31'h0, rsp_valid_a}, 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h10, 1'b1, 1'b0);
    checkOutput("flush_valid", {31'h0, rsp_valid_a}, 32'h0);
    #1;
    checkOutput("flush_rearm", {31'h0, req_ready_a}, 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_lat1", {31'h0, rsp_valid_a}, 32'h0);
    tick();
    checkOutput("flush_rsp_valid", {31'h0, rsp_valid_a}, 32'h1);
    checkOutput("flush_rsp_instr", rsp_instr_a, 32'hA000_0004);
    checkOutput("flush_rsp_addr", rsp_addr_a, 32'h10);
    tick();
    checkOutput("flush_only", {31'h0, rsp_valid_a}, 32'h0);

    // Reset with two fetches in flight and the consumer stalled.
    applyStimulus(1'b1, 1'b0, 32'h20, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h24, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("mid_pre_instr", rsp_instr_a, 32'hA000_0008);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_valid", {31'h0, rsp_valid_a}, 32'h0);
    checkOutput("mid_rst_instr", rsp_instr_a, 32'h0);
    checkOutput("mid_rst_addr", rsp_addr_a, 32'h0);
    checkOutput("mid_rst_err", {30'h0, rsp_err_a}, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h8, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("post_rst_lat1", {31'h0, rsp_valid_a}, 32'h0);
    tick();
    checkOutput("post_rst_valid", {31'h0, rsp_valid_a}, 32'h1);
    checkOutput("post_rst_instr", rsp_instr_a, 32'hA000_0002);
    checkOutput("post_rst_addr", rsp_addr_a, 32'h8);
    tick();
    checkOutput("post_rst_drain", {31'h0, rsp_valid_a}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
